// File: rtl/ccsds123_sample_gather.sv
// Purpose: packs PIPELINES consecutive D-bit stream samples into one wide beat for ccsds123_top.
// Latency: the beat is valid right after the edge that accepts its last sample, if the output register is free.
// Backpressure: one group held behind a full output register, then s_tready drops (registered, no comb path).
//
// Ports:
//   clk, aresetn                      rising-edge clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast one sample per beat; s_tlast marks the image's last sample
//   m_tdata/m_tvalid/m_tready/m_tlast packed group, lane i at [i*D +: D], lane 0 = earliest sample
//   m_tlanes                          number of valid lanes (PIPELINES except a short image-final group)
//   out_groups                        count of beats emitted since reset, wraps
module ccsds123_sample_gather #(
    parameter int PIPELINES = 3,
    parameter int D         = 16,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic [D-1:0]                   s_tdata,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    input  logic                           s_tlast,
    output logic [PIPELINES*D-1:0]         m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast,
    output logic [$clog2(PIPELINES+1)-1:0] m_tlanes,
    output logic [CNT_W-1:0]               out_groups
);

    localparam int W  = PIPELINES * D;
    localparam int LW = $clog2(PIPELINES + 1);
    localparam int KW = (PIPELINES > 1) ? $clog2(PIPELINES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(PIPELINES - 1);

    typedef enum logic {
        GATHER = 1'b0,
        HELD   = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            rdy_q;
    logic [KW-1:0]   k_q;
    logic [W-1:0]    asm_q;
    logic [W-1:0]    asm_wr;
    logic [LW-1:0]   held_lanes_q;
    logic            held_last_q;
    logic [LW-1:0]   lanes_now;

    logic accept;
    logic close;
    logic out_free;
    logic drain;
    logic load_new;
    logic load_held;

    assign s_tready  = rdy_q;
    assign accept    = s_tvalid && rdy_q;
    assign close     = accept && ((k_q == K_LAST) || s_tlast);
    assign drain     = m_tvalid && m_tready;
    assign out_free  = !m_tvalid || m_tready;
    assign lanes_now = LW'(k_q) + LW'(1);

    // Lanes above k are always zero because the assembly register is cleared
    // whenever a group leaves it, so a short group comes out zero padded.
    always_comb begin
        asm_wr = asm_q;
        for (int i = 0; i < PIPELINES; i++) begin
            if (k_q == KW'(i)) begin
                asm_wr[i*D +: D] = s_tdata;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= GATHER;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_new  = 1'b0;
        load_held = 1'b0;
        unique case (state_q)
            GATHER: begin
                if (close) begin
                    if (out_free) begin
                        load_new = 1'b1;
                    end else begin
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                // The held group replaces the beat leaving the output register on the same edge.
                if (drain) begin
                    load_held = 1'b1;
                    state_d   = GATHER;
                end
            end
            default: state_d = GATHER;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q        <= 1'b0;
            k_q          <= '0;
            asm_q        <= '0;
            held_lanes_q <= '0;
            held_last_q  <= 1'b0;
            m_tdata      <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tlanes     <= '0;
            out_groups   <= '0;
        end else begin
            // Ready follows the next state, so it rises on the first edge after reset release
            // and falls the cycle after a group gets parked.
            rdy_q <= (state_d == GATHER);

            if (accept) begin
                k_q <= close ? '0 : k_q + KW'(1);
                if (close && load_new) begin
                    asm_q <= '0;
                end else begin
                    asm_q <= asm_wr;
                end
                if (close && !load_new) begin
                    held_lanes_q <= lanes_now;
                    held_last_q  <= s_tlast;
                end
            end else if (load_held) begin
                asm_q <= '0;
            end

            if (load_new) begin
                m_tdata  <= asm_wr;
                m_tlanes <= lanes_now;
                m_tlast  <= s_tlast;
                m_tvalid <= 1'b1;
            end else if (load_held) begin
                m_tdata  <= asm_q;
                m_tlanes <= held_lanes_q;
                m_tlast  <= held_last_q;
                m_tvalid <= 1'b1;
            end else if (drain) begin
                m_tvalid <= 1'b0;
            end

            if (drain) begin
                out_groups <= out_groups + CNT_W'(1);
            end
        end
    end

endmodule
